// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared state encoding and test-pattern function for the memory BIST master.
package mem_bist_pkg;
   typedef enum logic [2:0] {IDLE, WR, RD, WR_INV, RD_INV, DONE} state_t;
   function automatic logic [63:0] pat(input logic [63:0] addr, input logic [63:0] seed, input logic invert);
      return invert ? ~(seed ^ addr) : (seed ^ addr);
   endfunction
endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if: single-port valid/ready memory request bus.
interface mem_bist_if #(parameter int WIDTH = 16, parameter int ADDR_WIDTH = 6) ();
   logic wt_rd, valid, ready;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0] wdata, rdata;
   modport master(output wt_rd, addr, wdata, valid, input rdata, ready);
   modport slave(input wt_rd, addr, wdata, valid, output rdata, ready);
endinterface

// File: rtl/mem_bist_checker.sv
// mem_bist_checker: read-data compare, saturating error count, first-error address and pass flag.
module mem_bist_checker #(parameter int WIDTH = 16, parameter int ADDR_WIDTH = 6) (
   input logic clk, rst, clr, chk, fin,
   input logic [WIDTH-1:0] expected, rdata,
   input logic [ADDR_WIDTH-1:0] addr,
   output logic pass,
   output logic [ADDR_WIDTH+1:0] err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr
);
   logic mis;
   logic [ADDR_WIDTH+1:0] cnt_nxt;
   assign mis = chk && rdata != expected;
   assign cnt_nxt = err_count + (ADDR_WIDTH+2)'(mis && !(&err_count));
   always_ff @(posedge clk)
      if (rst || clr) begin
         err_count <= '0;
         first_err_addr <= '0;
         pass <= 1'b0;
      end else begin
         err_count <= cnt_nxt;
         if (mis && err_count == '0) first_err_addr <= addr;
         // the last read completes on the same edge that enters DONE, so judge the post-update count
         if (fin) pass <= cnt_nxt == '0;
      end
endmodule

// File: rtl/mem_bist_master.sv
// mem_bist_master: writes pat(a) to every location, reads back and checks on a valid/ready bus.
// Define MEM_BIST_INV_PASS_EN to append inverted-pattern write and read phases.
module mem_bist_master
   import mem_bist_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter logic [WIDTH-1:0] SEED = WIDTH'(16'hA5A5)
) (
   input logic clk, rst, start,
   output logic busy, done, pass,
   output logic [ADDR_WIDTH+1:0] err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   mem_bist_if.master m
);
   state_t state, nxt;
   logic [ADDR_WIDTH-1:0] nxt_addr;
   logic hs, last, clr, inv_rd, inv_wr, valid_d, wt_rd_d, done_d;
   logic [WIDTH-1:0] wdata_d, expected;
   assign hs = m.valid && m.ready;
   assign last = m.addr == ADDR_WIDTH'(DEPTH - 1);
   assign clr = state == IDLE && start;
   assign nxt_addr = clr || (hs && last) ? '0 : m.addr + ADDR_WIDTH'(hs);
`ifdef MEM_BIST_INV_PASS_EN
   assign inv_rd = state == RD_INV;
`else
   assign inv_rd = 1'b0;
`endif
   assign expected = WIDTH'(pat(64'(m.addr), 64'(SEED), inv_rd));
   assign busy = m.valid;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         m.addr <= '0;
         m.valid <= 1'b0;
         m.wt_rd <= 1'b0;
         m.wdata <= '0;
         done <= 1'b0;
      end else begin
         state <= nxt;
         m.addr <= nxt_addr;
         m.valid <= valid_d;
         m.wt_rd <= wt_rd_d;
         m.wdata <= wdata_d;
         done <= done_d;
      end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:   nxt = start ? WR : IDLE;
         WR:     nxt = hs && last ? RD : WR;
`ifdef MEM_BIST_INV_PASS_EN
         RD:     nxt = hs && last ? WR_INV : RD;
         WR_INV: nxt = hs && last ? RD_INV : WR_INV;
         RD_INV: nxt = hs && last ? DONE : RD_INV;
`else
         RD:     nxt = hs && last ? DONE : RD;
`endif
         default: nxt = IDLE;
      endcase
   end
   // outputs are computed from the next state/address so every bus signal leaves a flop
   always_comb begin
      wt_rd_d = nxt == WR;
      inv_wr = 1'b0;
`ifdef MEM_BIST_INV_PASS_EN
      wt_rd_d = nxt == WR || nxt == WR_INV;
      inv_wr = nxt == WR_INV;
`endif
      valid_d = nxt != IDLE && nxt != DONE;
      done_d = nxt == DONE;
      wdata_d = wt_rd_d ? WIDTH'(pat(64'(nxt_addr), 64'(SEED), inv_wr)) : '0;
   end
   mem_bist_checker #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_chk (
      .clk(clk), .rst(rst), .clr(clr), .chk(hs && !m.wt_rd), .fin(done_d),
      .expected(expected), .rdata(m.rdata), .addr(m.addr),
      .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
   );
endmodule

// File: doc/mem_bist_master.md
# mem_bist_master

Initiator for the single-port valid/ready memory interface (clk, rst, wt_rd, addr, wdata, rdata, valid, ready). On `start` it fills every location with a deterministic pattern, reads each location back, and compares it. It reports pass/fail, an error count and the first failing address. It sits between the system control logic and any memory responder on this interface, and it replaces bench-side write/read loops in silicon self-test.

## Interface
- WIDTH, 16, data width of wdata/rdata.
- DEPTH, 64, number of memory locations exercised (addresses 0..DEPTH-1).
- ADDR_WIDTH, $clog2(DEPTH), address width.
- SEED, 16'hA5A5 (truncated/zero-extended to WIDTH), pattern seed.
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin test; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  result of the last completed test; holds until the next start is accepted.
- err_count  out  ADDR_WIDTH+2  mismatching reads in the last test, saturating.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- wt_rd  out  1  1 = write, 0 = read.
- addr  out  ADDR_WIDTH  request address.
- wdata  out  WIDTH  write data; 0 during reads.
- rdata  in  WIDTH  read data from the responder.
- valid  out  1  request valid.
- ready  in  1  responder accepts / completes the request.

## Operation
- Transfer rule: a beat completes on a posedge where valid && ready. While valid is high and ready is low, wt_rd, addr and wdata are held stable.
- Read data: rdata is sampled on the completing edge of a read beat.
- Pattern: pat(a) = SEED ^ a, where a is zero-extended to WIDTH and the result is taken mod 2^WIDTH.
- State machine:
  - IDLE: start=1 -> WR.
  - WR: on each handshake addr increments. The handshake at addr=DEPTH-1 -> RD.
  - RD: each handshake compares rdata with pat(addr). The handshake at DEPTH-1 -> DONE, or -> WR_INV when the inverted-pass macro is defined.
  - DONE: one cycle -> IDLE.
- Mismatch handling: err_count increments and saturates at all-ones. On the first mismatch of a test, first_err_addr latches addr.
- pass = (err_count == 0) and is registered when entering DONE.
- Accepting start clears err_count and first_err_addr.
- start while busy is ignored.
- A responder that never asserts ready stalls the block indefinitely. There is no timeout.
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_addr=0, wt_rd=0, addr=0, wdata=0, valid=0, state=IDLE.
- Reset mid-test: valid drops on the reset edge, and the aborted test produces no done pulse.

## Timing
- Start latency: start high at edge N (in IDLE) gives valid=1, wt_rd=1, addr=0, wdata=pat(0) and busy=1 after edge N.
- Back-to-back beats: valid stays high across beats. After a handshake at edge K, the next address is presented immediately after edge K, so there is no bubble.
- Phase changes: the WR->RD transition is also bubble-free; valid stays 1, wt_rd goes to 0 and addr goes to 0.
- Best-case test length: 2*DEPTH handshake cycles, plus 1 DONE cycle.
- After the last read handshake, valid=0, done=1 and busy=0 in the following cycle.
- Output registration: all outputs are registered, with no combinational path from ready or rdata to any output.

## Configuration
- MEM_BIST_INV_PASS_EN defined:
  - After RD, two further phases run: WR_INV writes ~pat(a), then RD_INV checks ~pat(a).
  - Total length is 4*DEPTH beats.
  - Mismatches from all read phases accumulate into one err_count and one first_err_addr.
- MEM_BIST_INV_PASS_EN undefined: the WR_INV and RD_INV states and their logic are not compiled.

## Structure
- Package mem_bist_pkg holds:
  - the state enum (IDLE, WR, RD, WR_INV, RD_INV, DONE);
  - the pattern function pat(addr, seed, invert).
- Sub-module mem_bist_checker holds the compare logic, the saturating err_count and the first_err_addr latch. It is fed by the FSM with a check strobe, the expected value and rdata.
- The top level holds the FSM, the address counter and the interface drive.

## Test plan
- Zero-wait responder (ready tied 1) with a correct memory, DEPTH=64, SEED=16'hA5A5:
  - expect 128 consecutive handshake cycles;
  - addr 63 written with 16'hA59A;
  - done one cycle after the last read;
  - pass=1, err_count=0.
- Random-stall responder (ready deasserted about 50% of cycles): wt_rd, addr and wdata stay stable during every stall, and the result matches the zero-wait case.
- Stuck bit (responder forces rdata[0]=0) -> pass=0, err_count=32 (odd pat values), first_err_addr=0, since pat(0)=16'hA5A5 has bit 0 set.
- Corrupt location 5 only -> err_count=1, first_err_addr=5.
- rst asserted during RD at addr 10:
  - valid=0 after the reset edge, no done pulse;
  - a new start then runs a full clean test.
- With MEM_BIST_INV_PASS_EN, write-protect addr 7 (holds 0) -> 256 beats, err_count=2 (both read passes flag addr 7), first_err_addr=7, pass=0.
